// File: rtl/frame_painter.sv
// frame_painter
//   Display-side reader of the turf RAM. A start strobe launches one raster
//   scan of every cell (x inner, y outer). Each cell is read through the RAM
//   read port, mapped to a VGA colour and plotted two cycles later. An
//   optional overlay paints the four player heads white.
//
// Ports
//   CLOCK_50      system clock
//   reset         synchronous, active-high
//   start         one-cycle frame request, ignored while busy
//   show_players  enables the player-head overlay (sampled per pixel)
//   p1..p4        player positions {x[14:7], y[6:0]}
//   ram_address   RAM read address {x[14:7], y[6:0]}
//   ram_q         RAM read data, valid one cycle after ram_address
//   x, y, colour  pixel to the VGA adapter
//   plot          pixel-write strobe
//   busy          high from scan start until the frame is complete
//   frame_done    one-cycle pulse with the last plot of a frame
module frame_painter #(
   parameter int XMAX = 159,
   parameter int YMAX = 119
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic        show_players,
   input  logic [14:0] p1,
   input  logic [14:0] p2,
   input  logic [14:0] p3,
   input  logic [14:0] p4,
   output logic [14:0] ram_address,
   input  logic [2:0]  ram_q,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [7:0] XLAST = 8'(XMAX);
   localparam logic [6:0] YLAST = 7'(YMAX);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cx;          // S0 column counter
   logic [6:0]  cy;          // S0 row counter
   logic        drain_cnt;   // counts the two DRAIN cycles
   logic        scan_last;

   logic [7:0]  tag_x;       // S1 address tag, aligned with ram_q
   logic [6:0]  tag_y;
   logic        tag_valid;
   logic        overlay;

   // Only the team ink codes are displayed; every other code is background.
   function automatic logic [2:0] ink_map(input logic [2:0] code);
      case (code)
         3'b001, 3'b010, 3'b100, 3'b110: return code;
         default:                        return 3'b000;
      endcase
   endfunction

   // An off-grid position can never equal an in-grid tag, but the explicit
   // bound keeps that guarantee independent of the tag widths.
   function automatic logic head_hit(input logic [14:0] p,
                                     input logic [7:0]  tx,
                                     input logic [6:0]  ty);
      return (p[14:7] <= XLAST) && (p[6:0] <= YLAST) && (p == {tx, ty});
   endfunction

   assign scan_last   = (cx == XLAST) && (cy == YLAST);
   assign ram_address = {cx, cy};
   assign busy        = (state != IDLE);
   assign overlay     = show_players && (head_hit(p1, tag_x, tag_y) ||
                                         head_hit(p2, tag_x, tag_y) ||
                                         head_hit(p3, tag_x, tag_y) ||
                                         head_hit(p4, tag_x, tag_y));

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: the default is assigned first so every path drives state_nxt and
   // no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = SCAN;
         SCAN:    if (scan_last) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Address counters. They wrap to (0,0) after the last cell, so they read
   // zero in DRAIN and IDLE without any extra clearing.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cx        <= '0;
         cy        <= '0;
         drain_cnt <= 1'b0;
      end else begin
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         if (state == SCAN) begin
            if (cx == XLAST) begin
               cx <= '0;
               cy <= (cy == YLAST) ? 7'd0 : cy + 7'd1;
            end else begin
               cx <= cx + 8'd1;
            end
         end
      end
   end

   // S1 (tag aligned with ram_q) and S2 (registered VGA outputs).
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         tag_valid  <= 1'b0;
         tag_x      <= '0;
         tag_y      <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         plot       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         tag_valid  <= (state == SCAN);
         tag_x      <= cx;
         tag_y      <= cy;
         x          <= tag_x;
         y          <= tag_y;
         plot       <= tag_valid;
         colour     <= !tag_valid ? 3'b000 :
                       overlay    ? 3'b111 : ink_map(ram_q);
         frame_done <= tag_valid && (tag_x == XLAST) && (tag_y == YLAST);
      end
   end

endmodule
